// File: rtl/frame_strobe_gen_if.sv
// Request channel from the bitstream configuration controller to a column's
// frame-strobe sequencer: valid/ready handshake plus frame and column address.
interface frame_strobe_gen_if #(
  parameter int FrameSelectWidth = 5,
  parameter int ColSelectWidth   = 5
);
  logic                        req_valid;
  logic                        req_ready;
  logic [FrameSelectWidth-1:0] FrameAddress;
  logic [ColSelectWidth-1:0]   ColAddress;

  // Configuration controller side
  modport master (
    output req_valid,
    output FrameAddress,
    output ColAddress,
    input  req_ready
  );

  // Sequencer side
  modport slave (
    input  req_valid,
    input  FrameAddress,
    input  ColAddress,
    output req_ready
  );
endinterface

// File: rtl/frame_strobe_gen.sv
// Per-column frame-strobe sequencer. Accepts a frame-write request, drops it
// if it targets another column, flags out-of-range frame indices, and
// otherwise drives a one-hot FrameStrobe pulse framed by setup and hold
// intervals so FrameData is stable around the tile latch window.
module frame_strobe_gen #(
  parameter int MaxFramesPerCol  = 20,
  parameter int FrameSelectWidth = 5,
  parameter int ColSelectWidth   = 5,
  parameter int Col              = 0,
  parameter int SetupCycles      = 1,
  parameter int StrobeCycles     = 2,
  parameter int HoldCycles       = 1
) (
  input  logic                       UserCLK,
  input  logic                       resetn,
  frame_strobe_gen_if.slave          bus,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [7:0]  SETUP_LOAD  = 8'(SetupCycles - 1);
  localparam logic [7:0]  STROBE_LOAD = 8'(StrobeCycles - 1);
  localparam logic [7:0]  HOLD_LOAD   = 8'(HoldCycles - 1);
  localparam logic [31:0] FRAME_LIMIT = 32'(MaxFramesPerCol);

  state_t                      state_reg, state_next;
  logic [7:0]                  cnt_reg, cnt_next;
  logic [FrameSelectWidth-1:0] frame_reg, frame_next;
  logic [MaxFramesPerCol-1:0]  strobe_reg, strobe_next;
  logic                        done_reg, done_next;
  logic                        err_reg, err_next;
  logic [MaxFramesPerCol-1:0]  frame_onehot;
  logic                        accept;
  logic                        col_hit;
  logic                        frame_oob;

  // Decode the latched frame index into the strobe pattern, one bit per frame
  for (genvar gi = 0; gi < MaxFramesPerCol; gi++) begin : g_onehot
    assign frame_onehot[gi] = (32'(frame_reg) == gi);
  end

  assign accept    = bus.req_valid && (state_reg == IDLE);
  assign col_hit   = (bus.ColAddress == ColSelectWidth'(Col));
  assign frame_oob = (32'(bus.FrameAddress) >= FRAME_LIMIT);

  // Handshake and status decode straight from the state register
  assign bus.req_ready = (state_reg == IDLE);
  assign busy          = (state_reg != IDLE);
  assign FrameStrobe   = strobe_reg;
  assign done          = done_reg;
  assign err           = err_reg;

  // State, counter and registered outputs; reset clears the strobe immediately
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      frame_reg  <= '0;
      strobe_reg <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      frame_reg  <= frame_next;
      strobe_reg <= strobe_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  // Sequencing: filter the request, then walk setup -> strobe -> hold
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    frame_next  = frame_reg;
    strobe_next = strobe_reg;
    done_next   = 1'b0;
    err_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        strobe_next = '0;
        if (accept && col_hit) begin
          if (frame_oob) begin
            err_next = 1'b1;
          end else begin
            frame_next = bus.FrameAddress;
            cnt_next   = SETUP_LOAD;
            state_next = SETUP;
          end
        end
      end
      SETUP: begin
        if (cnt_reg == 8'd0) begin
          state_next  = STROBE;
          cnt_next    = STROBE_LOAD;
          strobe_next = frame_onehot;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      STROBE: begin
        if (cnt_reg == 8'd0) begin
          state_next  = HOLD;
          cnt_next    = HOLD_LOAD;
          strobe_next = '0;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      HOLD: begin
        strobe_next = '0;
        if (cnt_reg == 8'd0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      default: begin
        state_next  = IDLE;
        strobe_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_frame_strobe_gen.sv
// Bench for frame_strobe_gen: a timeline model schedules the expected outputs
// for each accepted request and is compared every cycle, alongside directed
// literal checks of the main scenarios.
module tb_frame_strobe_gen;

  localparam int NF    = 20;
  localparam int COL   = 0;
  localparam int S     = 1;
  localparam int T     = 2;
  localparam int H     = 1;
  localparam int DEPTH = 1024;

  logic          clk;
  logic          resetn;
  logic [NF-1:0] FrameStrobe;
  logic          busy;
  logic          done;
  logic          err;

  frame_strobe_gen_if #(.FrameSelectWidth(5), .ColSelectWidth(5)) bus ();

  frame_strobe_gen #(
    .MaxFramesPerCol (NF),
    .FrameSelectWidth(5),
    .ColSelectWidth  (5),
    .Col             (COL),
    .SetupCycles     (S),
    .StrobeCycles    (T),
    .HoldCycles      (H)
  ) dut (
    .UserCLK    (clk),
    .resetn     (resetn),
    .bus        (bus),
    .FrameStrobe(FrameStrobe),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model timeline: index = period following posedge number n
  logic [NF-1:0] exp_strobe [DEPTH];
  logic          exp_busy   [DEPTH];
  logic          exp_done   [DEPTH];
  logic          exp_err    [DEPTH];
  int            cyc = 0;
  int            next_accept = 0;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      exp_strobe[i] = '0;
      exp_busy[i]   = 1'b0;
      exp_done[i]   = 1'b0;
      exp_err[i]    = 1'b0;
    end
  end

  // Model update at each edge, comparison mid-period
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (resetn && bus.req_valid && cyc >= next_accept && cyc + S + T + H + 1 < DEPTH) begin
      if (int'(bus.ColAddress) != COL) begin
        // consumed silently
      end else if (int'(bus.FrameAddress) >= NF) begin
        exp_err[cyc] = 1'b1;
      end else begin
        for (int k = 0; k < S + T + H; k++) exp_busy[cyc + k] = 1'b1;
        for (int k = S; k < S + T; k++) exp_strobe[cyc + k] = NF'(1) << bus.FrameAddress;
        exp_done[cyc + S + T + H] = 1'b1;
        next_accept = cyc + S + T + H + 1;
      end
    end
    #4;
    if (!resetn) begin
      chk("rst_strobe", 32'(FrameStrobe), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      for (int i = cyc; i < DEPTH; i++) begin
        exp_strobe[i] = '0;
        exp_busy[i]   = 1'b0;
        exp_done[i]   = 1'b0;
        exp_err[i]    = 1'b0;
      end
      next_accept = 0;
    end else if (cyc < DEPTH) begin
      chk("model_strobe", 32'(FrameStrobe), 32'(exp_strobe[cyc]));
      chk("model_busy", 32'(busy), 32'(exp_busy[cyc]));
      chk("model_ready", 32'(bus.req_ready), 32'(!exp_busy[cyc]));
      chk("model_done", 32'(done), 32'(exp_done[cyc]));
      chk("model_err", 32'(err), 32'(exp_err[cyc]));
      chk("onehot", 32'($countones(FrameStrobe) > 1), 32'd0);
    end
  end

  // Present a request and wait (bounded) until it is accepted; called at +1
  task automatic send(input int fa, input int ca, input bit keep_valid, output bit saw_done);
    int n;
    n = 0;
    bus.FrameAddress = 5'(fa);
    bus.ColAddress   = 5'(ca);
    bus.req_valid    = 1'b1;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_timeout", 32'(n >= 50), 32'd0);
    saw_done = done;
    @(posedge clk); #1;
    if (!keep_valid) bus.req_valid = 1'b0;
  endtask

  logic [NF-1:0] s_tab [6];
  logic          b_tab [6];
  logic          d_tab [6];
  bit            d0, d1;
  int            cnt19;

  initial begin
    s_tab = '{20'h0, 20'h00080, 20'h00080, 20'h0, 20'h0, 20'h0};
    b_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    d_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    resetn           = 1'b0;
    bus.req_valid    = 1'b0;
    bus.FrameAddress = '0;
    bus.ColAddress   = '0;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", 32'(bus.req_ready), 32'd1);
    chk("idle_strobe", 32'(FrameStrobe), 32'd0);
    chk("idle_busy_done_err", {29'd0, busy, done, err}, 32'd0);

    // Single frame 7: table covers cycles 1..6
    send(7, 0, 1'b0, d0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("single_strobe_c%0d", k + 1), 32'(FrameStrobe), 32'(s_tab[k]));
      chk($sformatf("single_busy_c%0d", k + 1), 32'(busy), 32'(b_tab[k]));
      chk($sformatf("single_done_c%0d", k + 1), 32'(done), 32'(d_tab[k]));
      @(posedge clk); #1;
    end

    // Column filter
    send(4, 3, 1'b0, d0);
    for (int k = 0; k < 3; k++) begin
      chk("colfilt_ready", 32'(bus.req_ready), 32'd1);
      chk("colfilt_strobe", 32'(FrameStrobe), 32'd0);
      chk("colfilt_done_err", {30'd0, done, err}, 32'd0);
      @(posedge clk); #1;
    end

    // Range error
    send(20, 0, 1'b0, d0);
    chk("range_err_c1", 32'(err), 32'd1);
    chk("range_ready_c1", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    chk("range_err_c2", 32'(err), 32'd0);
    chk("range_strobe", 32'(FrameStrobe), 32'd0);
    @(posedge clk); #1;

    // Back-to-back: frame 0 then 19 with valid held high
    send(0, 0, 1'b1, d0);
    send(19, 0, 1'b0, d1);
    chk("b2b_accept_on_done", 32'(d1), 32'd1);
    cnt19 = (FrameStrobe == 20'h80000) ? 1 : 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (FrameStrobe == 20'h80000) cnt19++;
    end
    chk("b2b_f19_width", 32'(cnt19), 32'd2);

    // Reset during cycle 2 of frame 5
    send(5, 0, 1'b0, d0);
    @(posedge clk); #1;
    chk("pre_rst_strobe", 32'(FrameStrobe), 32'h00020);
    #1 resetn = 1'b0;
    #1 chk("rst_async_strobe", 32'(FrameStrobe), 32'd0);
    @(posedge clk); #1 resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
      chk("post_rst_done", 32'(done), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
